// File: rtl/icw_ocw_sequencer.sv
// 8259-style ICW/OCW sequencer: edge-detects the write flags, walks the init
// sequence, holds the config registers and decodes OCW1..3 into IMR/pulses.
//
// Ports
//   clk, rst (async, active-low)
//   writeICW1, writeICW2to4, writeOCW1..3 : level flags, one event per rising level
//   internalDataBus                       : data byte for the flagged write
//   init_done                             : high while in READY
//   ltim, single_mode, vector_base        : ICW1/ICW2 configuration
//   cascade_cfg                           : ICW3 byte
//   aeoi, buf_ms, sfnm                    : ICW4 configuration
//   imr                                   : OCW1 mask
//   eoi_pulse, eoi_specific, rotate       : OCW2 EOI command
//   cmd_level, set_prio_pulse             : OCW2 level and set-priority
//   read_isr, smm, poll_pulse             : OCW3 state
//   rotate_in_aeoi                        : OCW2 rotate-in-AEOI mode
// Build option: define ROTATE_AEOI_EN to enable the rotate_in_aeoi mode.
module icw_ocw_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeICW1,
  input  logic              writeICW2to4,
  input  logic              writeOCW1,
  input  logic              writeOCW2,
  input  logic              writeOCW3,
  input  logic [DATA_W-1:0] internalDataBus,
  output logic              init_done,
  output logic              ltim,
  output logic              single_mode,
  output logic [4:0]        vector_base,
  output logic [7:0]        cascade_cfg,
  output logic              aeoi,
  output logic [1:0]        buf_ms,
  output logic              sfnm,
  output logic [7:0]        imr,
  output logic              eoi_pulse,
  output logic              eoi_specific,
  output logic              rotate,
  output logic [2:0]        cmd_level,
  output logic              set_prio_pulse,
  output logic              read_isr,
  output logic              smm,
  output logic              poll_pulse,
  output logic              rotate_in_aeoi
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_e;

  state_e state_q, state_d;

  logic [4:0] flg_q;
  logic [4:0] flags;
  logic [4:0] ev;
  logic [7:0] d;

  logic       ev_icw1, ev_w24, ev_o1, ev_o2, ev_o3;
  logic       rdy;

  logic       done_q, done_d;
  logic       ltim_q, ltim_d;
  logic       single_q, single_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vb_q, vb_d;
  logic [7:0] cas_q, cas_d;
  logic       aeoi_q, aeoi_d;
  logic [1:0] bufms_q, bufms_d;
  logic       sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       eoip_q, eoip_d;
  logic       eoisp_q, eoisp_d;
  logic       rot_q, rot_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spp_q, spp_d;
  logic       risr_q, risr_d;
  logic       smm_q, smm_d;
  logic       poll_q, poll_d;
`ifdef ROTATE_AEOI_EN
  logic       raeoi_q, raeoi_d;
`endif

  assign d     = internalDataBus[7:0];
  assign flags = {writeOCW3, writeOCW2, writeOCW1,
                  writeICW2to4, writeICW1};
  assign ev    = flags & ~flg_q;

  // Events made one-hot: ICW1 first, then a fixed order for the
  // (nominally impossible) coincidences of the others.
  assign ev_icw1 = ev[0];
  assign ev_w24  = ev[1] & ~ev[0];
  assign ev_o1   = ev[2] & ~|ev[1:0];
  assign ev_o2   = ev[3] & ~|ev[2:0];
  assign ev_o3   = ev[4] & ~|ev[3:0];

  assign rdy = (state_q == READY);

  always_comb begin
    state_d  = state_q;
    ltim_d   = ltim_q;
    single_d = single_q;
    ic4_d    = ic4_q;
    vb_d     = vb_q;
    cas_d    = cas_q;
    aeoi_d   = aeoi_q;
    bufms_d  = bufms_q;
    sfnm_d   = sfnm_q;
    imr_d    = imr_q;
    eoisp_d  = eoisp_q;
    rot_d    = rot_q;
    lvl_d    = lvl_q;
    risr_d   = risr_q;
    smm_d    = smm_q;
    eoip_d   = 1'b0;
    spp_d    = 1'b0;
    poll_d   = 1'b0;
`ifdef ROTATE_AEOI_EN
    raeoi_d  = raeoi_q;
`endif

    unique case (1'b1)
      ev_icw1: begin
        ltim_d   = d[3];
        single_d = d[1];
        ic4_d    = d[0];
        imr_d    = 8'h00;
        smm_d    = 1'b0;
        risr_d   = 1'b0;
        aeoi_d   = 1'b0;
        bufms_d  = 2'b00;
        sfnm_d   = 1'b0;
`ifdef ROTATE_AEOI_EN
        raeoi_d  = 1'b0;
`endif
        if (d[1]) cas_d = 8'h00;
        state_d  = WAIT_ICW2;
      end
      ev_w24: begin
        unique case (state_q)
          WAIT_ICW2: begin
            vb_d = d[7:3];
            if (!single_q)  state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
          WAIT_ICW3: begin
            cas_d   = d;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            sfnm_d  = d[4];
            bufms_d = d[3:2];
            aeoi_d  = d[1];
            state_d = READY;
          end
          default: ;
        endcase
      end
      ev_o1: begin
        if (rdy) imr_d = d;
      end
      ev_o2: begin
        if (rdy) begin
          if (d[5]) begin
            eoip_d  = 1'b1;
            eoisp_d = d[6];
            rot_d   = d[7];
            lvl_d   = d[2:0];
          end else if (d[7:6] == 2'b11) begin
            spp_d = 1'b1;
            lvl_d = d[2:0];
          end
`ifdef ROTATE_AEOI_EN
          else if (d[7:6] == 2'b10) begin
            raeoi_d = 1'b1;
          end else if (d[7:6] == 2'b00) begin
            raeoi_d = 1'b0;
          end
`endif
        end
      end
      ev_o3: begin
        if (rdy) begin
          if (d[1]) risr_d = d[0];
          if (d[6]) smm_d  = d[5];
          if (d[2]) poll_d = 1'b1;
        end
      end
      default: ;
    endcase

    done_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flg_q    <= '0;
      done_q   <= 1'b0;
      ltim_q   <= 1'b0;
      single_q <= 1'b0;
      ic4_q    <= 1'b0;
      vb_q     <= '0;
      cas_q    <= '0;
      aeoi_q   <= 1'b0;
      bufms_q  <= '0;
      sfnm_q   <= 1'b0;
      imr_q    <= '0;
      eoip_q   <= 1'b0;
      eoisp_q  <= 1'b0;
      rot_q    <= 1'b0;
      lvl_q    <= '0;
      spp_q    <= 1'b0;
      risr_q   <= 1'b0;
      smm_q    <= 1'b0;
      poll_q   <= 1'b0;
    end else begin
      flg_q    <= flags;
      done_q   <= done_d;
      ltim_q   <= ltim_d;
      single_q <= single_d;
      ic4_q    <= ic4_d;
      vb_q     <= vb_d;
      cas_q    <= cas_d;
      aeoi_q   <= aeoi_d;
      bufms_q  <= bufms_d;
      sfnm_q   <= sfnm_d;
      imr_q    <= imr_d;
      eoip_q   <= eoip_d;
      eoisp_q  <= eoisp_d;
      rot_q    <= rot_d;
      lvl_q    <= lvl_d;
      spp_q    <= spp_d;
      risr_q   <= risr_d;
      smm_q    <= smm_d;
      poll_q   <= poll_d;
    end
  end

`ifdef ROTATE_AEOI_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) raeoi_q <= 1'b0;
    else      raeoi_q <= raeoi_d;
  end
  assign rotate_in_aeoi = raeoi_q;
`else
  assign rotate_in_aeoi = 1'b0;
`endif

  assign init_done      = done_q;
  assign ltim           = ltim_q;
  assign single_mode    = single_q;
  assign vector_base    = vb_q;
  assign cascade_cfg    = cas_q;
  assign aeoi           = aeoi_q;
  assign buf_ms         = bufms_q;
  assign sfnm           = sfnm_q;
  assign imr            = imr_q;
  assign eoi_pulse      = eoip_q;
  assign eoi_specific   = eoisp_q;
  assign rotate         = rot_q;
  assign cmd_level      = lvl_q;
  assign set_prio_pulse = spp_q;
  assign read_isr       = risr_q;
  assign smm            = smm_q;
  assign poll_pulse     = poll_q;

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Bench for icw_ocw_sequencer: directed test-plan steps then random writes,
// checked against a queue-based model of the init sequence.
module tb_icw_ocw_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] fl  = '0;
  logic [7:0] bus = '0;

  logic       init_done, ltim, single_mode, aeoi, sfnm;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic [1:0] buf_ms;
  logic       eoi_pulse, eoi_specific, rotate, set_prio_pulse;
  logic [2:0] cmd_level;
  logic       read_isr, smm, poll_pulse, rotate_in_aeoi;

  always #5 clk = ~clk;

  icw_ocw_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .writeICW1(fl[0]), .writeICW2to4(fl[1]),
    .writeOCW1(fl[2]), .writeOCW2(fl[3]), .writeOCW3(fl[4]),
    .internalDataBus(bus),
    .init_done(init_done), .ltim(ltim), .single_mode(single_mode),
    .vector_base(vector_base), .cascade_cfg(cascade_cfg),
    .aeoi(aeoi), .buf_ms(buf_ms), .sfnm(sfnm), .imr(imr),
    .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific),
    .rotate(rotate), .cmd_level(cmd_level),
    .set_prio_pulse(set_prio_pulse), .read_isr(read_isr),
    .smm(smm), .poll_pulse(poll_pulse),
    .rotate_in_aeoi(rotate_in_aeoi)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: configuration values plus the list of ICW steps
  // still owed by the current init sequence (2, 3, 4).
  int         steps[$];
  bit         m_active;
  logic       m_ltim, m_single, m_aeoi, m_sfnm;
  logic [4:0] m_vb;
  logic [7:0] m_cas, m_imr;
  logic [1:0] m_bufms;
  logic       m_eoip, m_eoisp, m_rot, m_spp;
  logic [2:0] m_lvl;
  logic       m_risr, m_smm, m_poll, m_raeoi;

  function automatic bit m_ready();
    return m_active && steps.size() == 0;
  endfunction

  function automatic void m_reset();
    steps.delete();
    m_active = 0;
    {m_ltim, m_single, m_aeoi, m_sfnm} = '0;
    m_vb = '0; m_cas = '0; m_imr = '0; m_bufms = '0;
    {m_eoip, m_eoisp, m_rot, m_spp} = '0;
    m_lvl = '0;
    {m_risr, m_smm, m_poll, m_raeoi} = '0;
  endfunction

  function automatic void m_clr_pulses();
    m_eoip = 0; m_spp = 0; m_poll = 0;
  endfunction

  function automatic void apply(int k, logic [7:0] d);
    int s;
    case (k)
      0: begin
        m_ltim = d[3]; m_single = d[1];
        m_imr = 0; m_smm = 0; m_risr = 0;
        m_aeoi = 0; m_bufms = 0; m_sfnm = 0; m_raeoi = 0;
        if (d[1]) m_cas = 0;
        steps.delete();
        steps.push_back(2);
        if (!d[1]) steps.push_back(3);
        if (d[0]) steps.push_back(4);
        m_active = 1;
      end
      1: if (m_active && steps.size() > 0) begin
        s = steps.pop_front();
        if (s == 2) m_vb = d[7:3];
        else if (s == 3) m_cas = d;
        else begin
          m_sfnm = d[4]; m_bufms = d[3:2]; m_aeoi = d[1];
        end
      end
      2: if (m_ready()) m_imr = d;
      3: if (m_ready()) begin
        if (d[5]) begin
          m_eoip = 1; m_eoisp = d[6]; m_rot = d[7]; m_lvl = d[2:0];
        end else if (d[7:5] == 3'b110) begin
          m_spp = 1; m_lvl = d[2:0];
        end
`ifdef ROTATE_AEOI_EN
        else if (d[7:5] == 3'b100) m_raeoi = 1;
        else if (d[7:5] == 3'b000) m_raeoi = 0;
`endif
      end
      4: if (m_ready()) begin
        if (d[1]) m_risr = d[0];
        if (d[6]) m_smm = d[5];
        if (d[2]) m_poll = 1;
      end
      default: ;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".init_done"}, 8'(init_done), 8'(m_ready()));
    chk({tag, ".ltim"}, 8'(ltim), 8'(m_ltim));
    chk({tag, ".single"}, 8'(single_mode), 8'(m_single));
    chk({tag, ".vb"}, 8'(vector_base), 8'(m_vb));
    chk({tag, ".cas"}, cascade_cfg, m_cas);
    chk({tag, ".aeoi"}, 8'(aeoi), 8'(m_aeoi));
    chk({tag, ".buf_ms"}, 8'(buf_ms), 8'(m_bufms));
    chk({tag, ".sfnm"}, 8'(sfnm), 8'(m_sfnm));
    chk({tag, ".imr"}, imr, m_imr);
    chk({tag, ".eoi_p"}, 8'(eoi_pulse), 8'(m_eoip));
    chk({tag, ".eoi_sp"}, 8'(eoi_specific), 8'(m_eoisp));
    chk({tag, ".rot"}, 8'(rotate), 8'(m_rot));
    chk({tag, ".lvl"}, 8'(cmd_level), 8'(m_lvl));
    chk({tag, ".spp"}, 8'(set_prio_pulse), 8'(m_spp));
    chk({tag, ".risr"}, 8'(read_isr), 8'(m_risr));
    chk({tag, ".smm"}, 8'(smm), 8'(m_smm));
    chk({tag, ".poll"}, 8'(poll_pulse), 8'(m_poll));
    chk({tag, ".raeoi"}, 8'(rotate_in_aeoi), 8'(m_raeoi));
  endtask

  // One write: flag k high for 'hold' cycles, then low for one.
  task automatic wr(int k, logic [7:0] d, int hold);
    @(negedge clk);
    fl = 5'(1 << k);
    bus = d;
    @(posedge clk); #1;
    apply(k, d);
    check_all("ev");
    m_clr_pulses();
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check_all("hold");
    end
    @(negedge clk);
    fl = '0;
    bus = 8'($urandom);
    @(posedge clk); #1;
    check_all("idle");
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 0;
    #1;
    m_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int r, k;
    m_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1;

    // full init with cascade
    wr(0, 8'h11, 1);
    wr(1, 8'h20, 1);
    wr(1, 8'h04, 1);
    chk("tp1.not_done", 8'(init_done), 8'h00);
    @(negedge clk); fl = 5'b00010; bus = 8'h01;
    @(posedge clk); #1;
    apply(1, 8'h01);
    chk("tp1.done_edge", 8'(init_done), 8'h01);
    chk("tp1.vb", 8'(vector_base), 8'h04);
    chk("tp1.cas", cascade_cfg, 8'h04);
    @(negedge clk); fl = '0;
    @(posedge clk); #1; check_all("tp1");

    // short init
    wr(0, 8'h12, 1);
    wr(1, 8'h48, 1);
    chk("tp2.done", 8'(init_done), 8'h01);
    chk("tp2.vb", 8'(vector_base), 8'h09);
    wr(1, 8'hFF, 2);
    chk("tp2.ign_vb", 8'(vector_base), 8'h09);
    wr(2, 8'hA5, 1);
    chk("tp2.imr", imr, 8'hA5);

    // held OCW2 strobes
    wr(3, 8'h63, 3);
    chk("tp3.lvl", 8'(cmd_level), 8'h03);
    chk("tp3.sl", 8'(eoi_specific), 8'h01);
    wr(3, 8'hC5, 2);
    chk("tp3.lvl5", 8'(cmd_level), 8'h05);

    // OCW3
    wr(4, 8'h0B, 1);
    chk("tp4.risr", 8'(read_isr), 8'h01);
    wr(4, 8'h68, 1);
    chk("tp4.smm", 8'(smm), 8'h01);
    wr(4, 8'h0C, 2);
    chk("tp4.risr_keep", 8'(read_isr), 8'h01);

    // rotate-in-AEOI codes
    wr(3, 8'h80, 1);
    wr(3, 8'h00, 1);

    // re-init from WAIT_ICW3
    wr(0, 8'h11, 1);
    wr(1, 8'h30, 1);
    wr(0, 8'h11, 1);
    chk("tp5.imr", imr, 8'h00);
    chk("tp5.done", 8'(init_done), 8'h00);
    wr(2, 8'h5A, 1);
    chk("tp5.imr_ign", imr, 8'h00);

    // coincident ICW1 + OCW1: ICW1 wins
    @(negedge clk); fl = 5'b00101; bus = 8'h13;
    @(posedge clk); #1;
    apply(0, 8'h13);
    check_all("coinc");
    @(negedge clk); fl = '0;
    @(posedge clk); #1; check_all("coinc2");

    // async reset mid-sequence
    wr(1, 8'h77, 1);
    async_reset();
    wr(2, 8'hFF, 1);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset();
      end else begin
        k = (r < 10) ? 0 : (r < 35) ? 1 : (r < 52) ? 2 :
            (r < 78) ? 3 : 4;
        wr(k, 8'($urandom), $urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
